// File: rtl/atm_session_driver_if.sv
// Host-side request/response channels of the ATM session driver.
// The host takes the master modport, the driver the slave modport.
interface atm_session_driver_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_operation;
   logic [3:0]  req_acc_num;
   logic [13:0] req_pin;
   logic [13:0] req_new_pin;
   logic [15:0] req_amount;
   logic        req_language;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_balance;
   logic        rsp_success;
   logic [2:0]  rsp_state;
   logic        rsp_error;

   modport master (
      output req_valid, req_operation, req_acc_num, req_pin, req_new_pin,
             req_amount, req_language, rsp_ready,
      input  req_ready, rsp_valid, rsp_balance, rsp_success, rsp_state, rsp_error
   );

   modport slave (
      input  req_valid, req_operation, req_acc_num, req_pin, req_new_pin,
             req_amount, req_language, rsp_ready,
      output req_ready, rsp_valid, rsp_balance, rsp_success, rsp_state, rsp_error
   );
endinterface

// File: rtl/atm_session_driver.sv
// ATM session driver: accepts one host request, applies it to the ATM for a
// fixed hold window, captures the ATM results and hands them back to the host.
// The ATM is held idle (atm_rst low) whenever no request is running.
module atm_session_driver #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned HOLD_LONG   = 6
) (
   input  logic         clk,
   input  logic         rst,
   atm_session_driver_if.slave host,
   output logic         atm_rst,
   output logic [2:0]   atm_operation,
   output logic [3:0]   atm_acc_num,
   output logic [13:0]  atm_pin,
   output logic [13:0]  atm_new_pin,
   output logic [15:0]  atm_amount,
   output logic         atm_language,
   input  logic [31:0]  atm_balance,
   input  logic         atm_success,
   input  logic [2:0]   atm_state,
   output logic         busy
);

   localparam int unsigned HOLD_MAX = (HOLD_CYCLES > HOLD_LONG) ? HOLD_CYCLES : HOLD_LONG;
   localparam int unsigned CW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CW-1:0] LOAD_SHORT = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] LOAD_LONG  = CW'(HOLD_LONG - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_RESPOND
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          req_bad;

   assign accept  = host.req_valid && host.req_ready;
   assign req_bad = (host.req_operation < 3'd3) ||
                    (host.req_pin > 14'd9999) ||
                    (host.req_new_pin > 14'd9999);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_nxt      = state;
      host.req_ready = 1'b0;
      host.rsp_valid = 1'b0;
      atm_rst        = 1'b0;
      busy           = 1'b1;
      case (state)
         S_IDLE: begin
            busy           = 1'b0;
            host.req_ready = !rst;
            if (accept) state_nxt = req_bad ? S_RESPOND : S_RUN;
         end
         S_RUN: begin
            atm_rst = 1'b1;
            if (cnt == '0) state_nxt = S_RESPOND;
         end
         S_RESPOND: begin
            host.rsp_valid = 1'b1;
            if (host.rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, hold counter and response capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt              <= '0;
         atm_operation    <= '0;
         atm_acc_num      <= '0;
         atm_pin          <= '0;
         atm_new_pin      <= '0;
         atm_amount       <= '0;
         atm_language     <= 1'b0;
         host.rsp_balance <= '0;
         host.rsp_success <= 1'b0;
         host.rsp_state   <= '0;
         host.rsp_error   <= 1'b0;
      end else begin
         if (state == S_IDLE && accept) begin
            if (req_bad) begin
               host.rsp_balance <= '0;
               host.rsp_success <= 1'b0;
               host.rsp_state   <= 3'd7;
               host.rsp_error   <= 1'b1;
            end else begin
               atm_operation <= host.req_operation;
               atm_acc_num   <= host.req_acc_num;
               atm_pin       <= host.req_pin;
               atm_new_pin   <= host.req_new_pin;
               atm_amount    <= host.req_amount;
               atm_language  <= host.req_language;
               cnt           <= (host.req_operation == 3'd7) ? LOAD_LONG : LOAD_SHORT;
            end
         end
         if (state == S_RUN) begin
            if (cnt == '0) begin
               host.rsp_balance <= atm_balance;
               host.rsp_success <= atm_success;
               host.rsp_state   <= atm_state;
               host.rsp_error   <= 1'b0;
            end else begin
               cnt <= cnt - CW'(1);
            end
         end
      end
   end

endmodule
